// File: rtl/noc_link_pkg.sv
// Shared definitions for NoC link-level blocks: flit word layout and credit counter sizing.
package noc_link_pkg;

  // Packed FIFO word layout, LSB first: data, then dest, then is_tail at the MSB.
  function automatic int unsigned flit_word_width(input int unsigned flit_w,
                                                  input int unsigned dest_w);
    return flit_w + dest_w + 1;
  endfunction

  function automatic int unsigned flit_dest_lsb(input int unsigned flit_w);
    return flit_w;
  endfunction

  function automatic int unsigned flit_tail_bit(input int unsigned flit_w,
                                                input int unsigned dest_w);
    return flit_w + dest_w;
  endfunction

  // Width of a counter that must hold 0..depth inclusive; also used by router credit counters.
  function automatic int unsigned credit_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// First-word-fall-through flit FIFO with extra-MSB pointers; reusable for router input buffers.
module noc_flit_fifo import noc_link_pkg::*; #(
  parameter int unsigned WIDTH = 39,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = credit_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              do_push;
  logic              do_pop;

  // Full when the low bits match but the wrap bits differ; empty when identical.
  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
              (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    count   = wr_ptr_q - rd_ptr_q;
    rdata   = mem[rd_ptr_q[ADDR_W-1:0]];
    // A push into a full FIFO is still legal when the head leaves in the same cycle.
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  // Pointer registers; clearing them discards all contents at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; no reset needed since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q[ADDR_W-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/noc_credit_link_buffer.sv
// Credit-managed link repeater: buffers upstream flits and forwards them while downstream credits
// remain, returning one upstream credit per forwarded flit.
module noc_credit_link_buffer import noc_link_pkg::*; #(
  parameter int unsigned FLIT_WIDTH         = 32,
  parameter int unsigned DEST_WIDTH         = 6,
  parameter int unsigned BUFFER_DEPTH       = 4,
  parameter int unsigned DOWNSTREAM_CREDITS = 256,
  parameter int unsigned CREDIT_WIDTH       = credit_width(DOWNSTREAM_CREDITS),
  localparam int unsigned OCC_W             = credit_width(BUFFER_DEPTH)
) (
  input  logic                  clk_noc,
  input  logic                  rst_noc,
  input  logic [FLIT_WIDTH-1:0] data_in,
  input  logic [DEST_WIDTH-1:0] dest_in,
  input  logic                  is_tail_in,
  input  logic                  send_in,
  output logic                  credit_out,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic [DEST_WIDTH-1:0] dest_out,
  output logic                  is_tail_out,
  output logic                  send_out,
  input  logic                  credit_in,
  output logic [OCC_W-1:0]      occupancy,
  output logic                  overflow_err,
  output logic                  credit_err
);

  localparam int unsigned WORD_W   = flit_word_width(FLIT_WIDTH, DEST_WIDTH);
  localparam int unsigned DEST_LSB = flit_dest_lsb(FLIT_WIDTH);
  localparam int unsigned TAIL_BIT = flit_tail_bit(FLIT_WIDTH, DEST_WIDTH);
  localparam logic [CREDIT_WIDTH-1:0] CreditMax = CREDIT_WIDTH'(DOWNSTREAM_CREDITS);

  logic [WORD_W-1:0]       wr_word;
  logic [WORD_W-1:0]       head_word;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    pop;
  logic [CREDIT_WIDTH-1:0] credit_cnt_q, credit_cnt_d;
  logic                    overflow_err_d;
  logic                    credit_err_d;

  assign wr_word = {is_tail_in, dest_in, data_in};

  noc_flit_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (BUFFER_DEPTH)
  ) u_fifo (
    .clk   (clk_noc),
    .rst   (rst_noc),
    .push  (send_in),
    .wdata (wr_word),
    .pop   (pop),
    .rdata (head_word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occupancy)
  );

  // Pop decision, credit counter next state and sticky error detection.
  always_comb begin
    pop            = !fifo_empty && (credit_cnt_q != '0);
    credit_cnt_d   = credit_cnt_q;
    overflow_err_d = overflow_err;
    credit_err_d   = credit_err;
    if (credit_in && !pop) begin
      if (credit_cnt_q == CreditMax) begin
        credit_err_d = 1'b1;
      end else begin
        credit_cnt_d = credit_cnt_q + 1'b1;
      end
    end else if (!credit_in && pop) begin
      credit_cnt_d = credit_cnt_q - 1'b1;
    end
    if (send_in && fifo_full && !pop) begin
      overflow_err_d = 1'b1;
    end
  end

  // Credit counter and sticky error flags.
  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      credit_cnt_q <= CreditMax;
      overflow_err <= 1'b0;
      credit_err   <= 1'b0;
    end else begin
      credit_cnt_q <= credit_cnt_d;
      overflow_err <= overflow_err_d;
      credit_err   <= credit_err_d;
    end
  end

  // Registered downstream flit and upstream credit; payload holds when nothing is popped.
  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      send_out    <= 1'b0;
      credit_out  <= 1'b0;
      data_out    <= '0;
      dest_out    <= '0;
      is_tail_out <= 1'b0;
    end else begin
      send_out   <= pop;
      credit_out <= pop;
      if (pop) begin
        data_out    <= head_word[FLIT_WIDTH-1:0];
        dest_out    <= head_word[TAIL_BIT-1:DEST_LSB];
        is_tail_out <= head_word[TAIL_BIT];
      end
    end
  end

endmodule

// File: tb/tb_noc_credit_link_buffer.sv
// Randomised and directed bench for noc_credit_link_buffer against a queue-based model.
module tb_noc_credit_link_buffer;

  localparam int unsigned FW = 32;
  localparam int unsigned DW = 6;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CREDITS = 2;

  typedef struct packed {
    logic [FW-1:0] d;
    logic [DW-1:0] dst;
    logic          t;
  } flit_t;

  logic          clk_noc = 1'b0;
  logic          rst_noc = 1'b1;
  logic [FW-1:0] data_in = '0;
  logic [DW-1:0] dest_in = '0;
  logic          is_tail_in = 1'b0;
  logic          send_in = 1'b0;
  logic          credit_in = 1'b0;
  logic          credit_out;
  logic [FW-1:0] data_out;
  logic [DW-1:0] dest_out;
  logic          is_tail_out;
  logic          send_out;
  logic [2:0]    occupancy;
  logic          overflow_err;
  logic          credit_err;

  noc_credit_link_buffer #(
    .FLIT_WIDTH         (FW),
    .DEST_WIDTH         (DW),
    .BUFFER_DEPTH       (DEPTH),
    .DOWNSTREAM_CREDITS (CREDITS)
  ) dut (
    .clk_noc      (clk_noc),
    .rst_noc      (rst_noc),
    .data_in      (data_in),
    .dest_in      (dest_in),
    .is_tail_in   (is_tail_in),
    .send_in      (send_in),
    .credit_out   (credit_out),
    .data_out     (data_out),
    .dest_out     (dest_out),
    .is_tail_out  (is_tail_out),
    .send_out     (send_out),
    .credit_in    (credit_in),
    .occupancy    (occupancy),
    .overflow_err (overflow_err),
    .credit_err   (credit_err)
  );

  always #5 clk_noc = ~clk_noc;

  int checks = 0;
  int failures = 0;
  int fwd = 0;
  bit chk_en = 1'b0;

  // Model state
  flit_t q[$];
  int    m_credits;
  bit    m_send, m_credit, m_ovf, m_cerr;
  flit_t m_out;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_credits = CREDITS;
    m_send = 0;
    m_credit = 0;
    m_ovf = 0;
    m_cerr = 0;
    m_out = '0;
  endtask

  // One clock edge of behaviour: forward the head if a credit exists, accept a push if room
  // exists (counting the slot freed by the pop), and track downstream credits.
  task automatic model_step(input bit s, input flit_t f, input bit cin);
    int pre;
    bit p;
    pre = q.size();
    p = (pre > 0) && (m_credits > 0);
    m_send = p;
    m_credit = p;
    if (p) m_out = q.pop_front();
    if (s) begin
      if (pre < DEPTH || p) q.push_back(f);
      else m_ovf = 1;
    end
    if (cin && !p) begin
      if (m_credits == CREDITS) m_cerr = 1;
      else m_credits++;
    end else if (!cin && p) begin
      m_credits--;
    end
  endtask

  task automatic tick(input bit s, input flit_t f, input bit cin);
    send_in = s;
    data_in = f.d;
    dest_in = f.dst;
    is_tail_in = f.t;
    credit_in = cin;
    @(posedge clk_noc);
    model_step(s, f, cin);
    @(negedge clk_noc);
    #1;
  endtask

  function automatic flit_t rnd_flit();
    flit_t f;
    f.d = $urandom;
    f.dst = DW'($urandom);
    f.t = 1'($urandom);
    return f;
  endfunction

  // Cycle-by-cycle comparison against the model while out of reset.
  always @(negedge clk_noc) begin
    if (chk_en && !rst_noc) begin
      chk("send_out", 64'(send_out), 64'(m_send));
      chk("credit_out", 64'(credit_out), 64'(m_credit));
      chk("flit_fields", {25'd0, is_tail_out, dest_out, data_out}, {25'd0, m_out.t, m_out.dst, m_out.d});
      chk("occupancy", 64'(occupancy), 64'(q.size()));
      chk("errors", {62'd0, overflow_err, credit_err}, {62'd0, m_ovf, m_cerr});
      if (send_out) fwd++;
    end
  end

  initial begin
    flit_t idle;
    flit_t f;
    idle = '0;
    model_reset();
    repeat (3) @(negedge clk_noc);
    rst_noc = 1'b0;
    #1;
    chk("reset_send", 64'(send_out), 64'd0);
    chk("reset_occ", 64'(occupancy), 64'd0);
    chk("reset_data", 64'(data_out), 64'd0);
    chk_en = 1'b1;

    // Single flit
    repeat (5) tick(0, idle, 0);
    f.d = 32'hDEADBEEF;
    f.dst = 6'h05;
    f.t = 1'b1;
    tick(1, f, 0);
    chk("single_occ_after_push", 64'(occupancy), 64'd1);
    chk("single_no_send_yet", 64'(send_out), 64'd0);
    tick(0, idle, 0);
    chk("single_send", 64'({send_out, credit_out}), 64'b11);
    chk("single_data", 64'(data_out), 64'hDEADBEEF);
    chk("single_dest_tail", 64'({dest_out, is_tail_out}), 64'h0B);
    chk("single_occ_zero", 64'(occupancy), 64'd0);
    tick(0, idle, 1);

    // Five back-to-back flits with two credits
    fwd = 0;
    for (int i = 0; i < 5; i++) tick(1, rnd_flit(), 0);
    repeat (2) tick(0, idle, 0);
    chk("b2b_forwarded", 64'(fwd), 64'd2);
    chk("b2b_occ", 64'(occupancy), 64'd3);
    tick(0, idle, 1);
    tick(0, idle, 0);
    chk("credit_release_send", 64'(send_out), 64'd1);
    chk("credit_release_occ", 64'(occupancy), 64'd2);

    // Fill and overflow
    for (int i = 0; i < 2; i++) tick(1, rnd_flit(), 0);
    chk("fill_occ", 64'(occupancy), 64'd4);
    chk("no_ovf_yet", 64'(overflow_err), 64'd0);
    tick(1, rnd_flit(), 0);
    chk("ovf_set", 64'(overflow_err), 64'd1);
    chk("ovf_occ", 64'(occupancy), 64'd4);

    // Credit and pop together at count 1
    tick(0, idle, 1);
    tick(0, idle, 1);
    chk("simul_send", 64'(send_out), 64'd1);
    tick(0, idle, 0);
    chk("simul_next_send", 64'(send_out), 64'd1);
    chk("simul_occ", 64'(occupancy), 64'd2);

    // Drain, then over-return a credit
    for (int i = 0; i < 20 && !(q.size() == 0 && m_credits == CREDITS); i++) tick(0, idle, 1);
    chk("no_cerr_yet", 64'(credit_err), 64'd0);
    tick(0, idle, 1);
    chk("cerr_set", 64'(credit_err), 64'd1);
    fwd = 0;
    for (int i = 0; i < 3; i++) tick(1, rnd_flit(), 0);
    repeat (2) tick(0, idle, 0);
    chk("sat_forwarded", 64'(fwd), 64'd2);
    chk("sat_occ", 64'(occupancy), 64'd1);

    // Asynchronous reset with three flits buffered
    for (int i = 0; i < 2; i++) tick(1, rnd_flit(), 0);
    chk("pre_reset_occ", 64'(occupancy), 64'd3);
    rst_noc = 1'b1;
    model_reset();
    #1;
    chk("rst_outputs", 64'({send_out, credit_out, is_tail_out, overflow_err, credit_err}), 64'd0);
    chk("rst_fields", 64'({dest_out, data_out}), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    @(negedge clk_noc);
    rst_noc = 1'b0;
    #1;
    fwd = 0;
    repeat (3) tick(0, idle, 0);
    chk("no_stale_flit", 64'(fwd), 64'd0);
    for (int i = 0; i < 3; i++) tick(1, rnd_flit(), 0);
    repeat (2) tick(0, idle, 0);
    chk("post_reset_forwarded", 64'(fwd), 64'd2);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 9) < 6), rnd_flit(), ($urandom_range(0, 99) < 35));
    end
    repeat (2) tick(0, idle, 0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
